mem_stall_responder: RTL and testbench

Multi-cycle data-memory responder that services the pipelined core's memory-stage load/store requests. The core is the initiator. This block is the target end of the same Rd/Wr/Stall/Done handshake. It accepts one word request, holds Stall high for a programmable latency, then commits the write or returns the read word with a one-cycle Done pulse. It replaces the single-cycle ideal memory so the core's stall and forwarding logic can be exercised under real back-pressure.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_array.sv | 37 +++
 rtl/mem_stall_responder.sv | 128 ++++++++++++
 tb/tb_mem_stall_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// The request-legality rule lives here so the top and any future wrapper agree on it.
package mem_resp_pkg;

   localparam int LATENCY_MAX = 15;
   localparam int WORD_W      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } respStateT;

   // A request is legal when exactly one of Rd/Wr is set and the byte address is word aligned.
   function automatic logic isLegal(input logic rd, input logic wr, input logic addrLsb);
      return (rd ^ wr) & ~addrLsb;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, synchronous registered read.
// Only the read register is reset; the array contents survive reset.
module mem_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  writeEn_i,
   input  logic                  readEn_i,
   input  logic [DEPTH_LOG2-1:0] wordIdx_i,
   input  logic [WORD_W-1:0]     writeData_i,
   output logic [WORD_W-1:0]     readData_o
);

   logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [WORD_W-1:0] readData_q;

   always_ff @(posedge clk) begin
      if (writeEn_i) begin
         mem_q[wordIdx_i] <= writeData_i;
      end
   end

   // The read register holds its value until the next read, so writes never disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         readData_q <= '0;
      end else if (readEn_i) begin
         readData_q <= mem_q[wordIdx_i];
      end
   end

   assign readData_o = readData_q;

endmodule

// File: rtl/mem_stall_responder.sv
// Target end of the Rd/Wr/Stall/Done handshake: accepts one word request, stalls the
// initiator for LATENCY cycles, then commits the write or returns the read word with Done.
module mem_stall_responder
   import mem_resp_pkg::*;
#(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] Addr,
   input  logic [WORD_W-1:0] DataIn,
   input  logic              Rd,
   input  logic              Wr,
   output logic [WORD_W-1:0] DataOut,
   output logic              Stall,
   output logic              Done,
   output logic              err
);

   localparam int LatEff = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                           ((LATENCY < 1) ? 1 : LATENCY);
   localparam logic [3:0] CntLoad = 4'(LatEff - 1);
   localparam logic       SingleCycle = (LatEff == 1);

   respStateT             state_q;
   logic [3:0]            cnt_q;
   logic                  opWrite_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [WORD_W-1:0]     data_q;
   logic                  done_q;

   logic                  reqValid;
   logic                  reqLegal;
   logic                  enterDone;
   logic                  memOpWrite;
   logic [DEPTH_LOG2-1:0] memIdx;
   logic [WORD_W-1:0]     memData;
   logic [DEPTH_LOG2-1:0] wordIdxIn;

   assign wordIdxIn = Addr[DEPTH_LOG2:1];

   generate
      if (DEPTH_LOG2 + 1 < WORD_W) begin : gUpperAddr
         logic unusedUpperAddr;
         assign unusedUpperAddr = ^Addr[WORD_W-1:DEPTH_LOG2+1];
      end
   endgenerate

   // Acceptance is gated by reset so a request held across reset never stalls or commits.
   // With a one-cycle latency the commit happens on the accept edge, so the live inputs
   // feed the array in IDLE and the latched copies are used otherwise.
   always_comb begin
      reqValid   = rst & (state_q == IDLE) & (Rd | Wr);
      reqLegal   = reqValid & isLegal(Rd, Wr, Addr[0]);
      err        = reqValid & ~isLegal(Rd, Wr, Addr[0]);
      Stall      = reqLegal | (state_q == BUSY);
      enterDone  = (reqLegal & SingleCycle) | ((state_q == BUSY) & (cnt_q == 4'd1));
      memOpWrite = opWrite_q;
      memIdx     = idx_q;
      memData    = data_q;
      if (state_q == IDLE) begin
         memOpWrite = Wr;
         memIdx     = wordIdxIn;
         memData    = DataIn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         opWrite_q <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (reqLegal) begin
                  opWrite_q <= Wr;
                  idx_q     <= wordIdxIn;
                  data_q    <= DataIn;
                  cnt_q     <= CntLoad;
                  if (SingleCycle) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            // Rd/Wr are still asserted here; returning to IDLE without looking at them
            // is what prevents the same request from being executed twice.
            DONE: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Done = done_q;

   mem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) uArray (
      .clk        (clk),
      .rst        (rst),
      .writeEn_i  (enterDone & memOpWrite),
      .readEn_i   (enterDone & ~memOpWrite),
      .wordIdx_i  (memIdx),
      .writeData_i(memData),
      .readData_o (DataOut)
   );

endmodule

// File: tb/tb_mem_stall_responder.sv
// Bench for mem_stall_responder: two instances (LATENCY 4 and 1) driven by directed
// transactions, checked every cycle against a timestamp-based transaction model.
module tb_mem_stall_responder;

   localparam int DepthLog2 = 10;
   localparam int NumWords  = 1 << DepthLog2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addrV    [2];
   logic [15:0] dataInV  [2];
   logic        rdV      [2];
   logic        wrV      [2];
   logic [15:0] dataOutW [2];
   logic        stallW   [2];
   logic        doneW    [2];
   logic        errW     [2];

   always #5 clk = ~clk;

   mem_stall_responder #(.LATENCY(4), .DEPTH_LOG2(DepthLog2)) dutA (
      .clk(clk), .rst(rst), .Addr(addrV[0]), .DataIn(dataInV[0]), .Rd(rdV[0]), .Wr(wrV[0]),
      .DataOut(dataOutW[0]), .Stall(stallW[0]), .Done(doneW[0]), .err(errW[0]));

   mem_stall_responder #(.LATENCY(1), .DEPTH_LOG2(DepthLog2)) dutB (
      .clk(clk), .rst(rst), .Addr(addrV[1]), .DataIn(dataInV[1]), .Rd(rdV[1]), .Wr(wrV[1]),
      .DataOut(dataOutW[1]), .Stall(stallW[1]), .Done(doneW[1]), .err(errW[1]));

   int          lat [2];
   logic [15:0] modelMem   [2][NumWords];
   bit          modelKnown [2][NumWords];
   bit          inFlight [2];
   int          accCycle [2];
   bit          opWrite  [2];
   int          opIdx    [2];
   logic [15:0] opData   [2];
   logic [15:0] expDout  [2];
   bit          doutKnown[2];
   logic        lastStall[2];
   logic        lastDone [2];
   logic        lastErr  [2];
   logic [15:0] lastDout [2];
   int          cyc;
   int          totalCount;
   int          badCount;

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      totalCount++;
      if (got !== exp) begin
         badCount++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   // A request accepted at cycle c stalls through c+L-1 and completes (Done, commit) at c+L.
   task automatic modelStep(input int d);
      logic expStall, expDone, expErr;
      bit   finish, isReq, legal;
      expStall = 1'b0;
      expDone  = 1'b0;
      expErr   = 1'b0;
      finish   = 1'b0;
      if (!rst) begin
         inFlight[d]  = 1'b0;
         expDout[d]   = 16'h0000;
         doutKnown[d] = 1'b1;
      end else if (inFlight[d]) begin
         if (cyc == accCycle[d] + lat[d]) begin
            expDone = 1'b1;
            finish  = 1'b1;
            if (opWrite[d]) begin
               modelMem[d][opIdx[d]]   = opData[d];
               modelKnown[d][opIdx[d]] = 1'b1;
            end else begin
               expDout[d]   = modelMem[d][opIdx[d]];
               doutKnown[d] = modelKnown[d][opIdx[d]];
            end
         end else begin
            expStall = 1'b1;
         end
      end else begin
         isReq    = rdV[d] | wrV[d];
         legal    = (rdV[d] != wrV[d]) && !addrV[d][0];
         expErr   = isReq && !legal;
         expStall = legal;
         if (legal) begin
            inFlight[d] = 1'b1;
            accCycle[d] = cyc;
            opWrite[d]  = wrV[d];
            opIdx[d]    = (int'(addrV[d]) >> 1) % NumWords;
            opData[d]   = dataInV[d];
         end
      end
      checkOutput($sformatf("dut%0d.Stall", d), {15'b0, stallW[d]}, {15'b0, expStall});
      checkOutput($sformatf("dut%0d.Done", d),  {15'b0, doneW[d]},  {15'b0, expDone});
      checkOutput($sformatf("dut%0d.err", d),   {15'b0, errW[d]},   {15'b0, expErr});
      if (doutKnown[d]) begin
         checkOutput($sformatf("dut%0d.DataOut", d), dataOutW[d], expDout[d]);
      end
      if (finish) begin
         inFlight[d] = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         lastStall[d] = stallW[d];
         lastDone[d]  = doneW[d];
         lastErr[d]   = errW[d];
         lastDout[d]  = dataOutW[d];
         modelStep(d);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int d = 0; d < 2; d++) begin
         rdV[d]     = 1'b0;
         wrV[d]     = 1'b0;
         addrV[d]   = 16'h0000;
         dataInV[d] = 16'h0000;
      end
      for (int i = 0; i < n; i++) tick();
   endtask

   // Initiator behaviour: hold the request until Stall is seen low (the Done cycle).
   task automatic applyStimulus(input int d, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [15:0] din,
                                output int stallCnt, output int doneOff, output int doneCnt);
      int n;
      bit stop;
      rdV[d]     = rd;
      wrV[d]     = wr;
      addrV[d]   = addr;
      dataInV[d] = din;
      stallCnt   = 0;
      doneOff    = -1;
      doneCnt    = 0;
      n          = 0;
      stop       = 1'b0;
      while (!stop) begin
         tick();
         if (lastStall[d] === 1'b1) stallCnt++;
         if (lastDone[d] === 1'b1) begin
            doneCnt++;
            if (doneOff < 0) doneOff = n;
         end
         n++;
         if (lastStall[d] !== 1'b1) begin
            stop = 1'b1;
         end else if (n >= 40) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL stallTimeout dut%0d: Stall still high after %0d cycles, required low", d, n);
            stop = 1'b1;
         end
      end
   endtask

   initial begin
      int sc, doff, dc;
      lat[0]     = 4;
      lat[1]     = 1;
      cyc        = 0;
      totalCount = 0;
      badCount   = 0;
      for (int d = 0; d < 2; d++) begin
         inFlight[d]  = 1'b0;
         expDout[d]   = 16'h0000;
         doutKnown[d] = 1'b1;
         rdV[d]       = 1'b0;
         wrV[d]       = 1'b0;
         addrV[d]     = 16'h0000;
         dataInV[d]   = 16'h0000;
      end
      #2 rst = 1'b0;
      tick();
      tick();
      checkOutput("reset.DataOut", lastDout[0], 16'h0000);
      checkOutput("reset.Stall", {15'b0, lastStall[0]}, 16'h0000);
      checkOutput("reset.Done", {15'b0, lastDone[0]}, 16'h0000);
      rst = 1'b1;
      idle(1);

      $display("[TB] write BEEF then read back on LATENCY=4");
      applyStimulus(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, sc, doff, dc);
      checkOutput("wr.stallCycles", 16'(sc), 16'd4);
      checkOutput("wr.doneOffset", 16'(doff), 16'd4);
      checkOutput("wr.DataOutHeld", lastDout[0], 16'h0000);
      applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000, sc, doff, dc);
      checkOutput("rd.doneOffset", 16'(doff), 16'd4);
      checkOutput("rd.doneCount", 16'(dc), 16'd1);
      checkOutput("rd.DataOut", lastDout[0], 16'hBEEF);
      idle(2);

      $display("[TB] illegal requests");
      applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h1234, sc, doff, dc);
      checkOutput("rdwr.err", {15'b0, lastErr[0]}, 16'h0001);
      checkOutput("rdwr.stallCycles", 16'(sc), 16'd0);
      idle(1);
      applyStimulus(0, 1'b0, 1'b1, 16'h0011, 16'h5555, sc, doff, dc);
      checkOutput("odd.err", {15'b0, lastErr[0]}, 16'h0001);
      checkOutput("odd.stallCycles", 16'(sc), 16'd0);
      idle(1);
      applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000, sc, doff, dc);
      checkOutput("illegal.arrayKept", lastDout[0], 16'hBEEF);
      idle(1);

      $display("[TB] reset during a write");
      applyStimulus(0, 1'b0, 1'b1, 16'h0020, 16'h1111, sc, doff, dc);
      idle(1);
      rdV[0]     = 1'b0;
      wrV[0]     = 1'b1;
      addrV[0]   = 16'h0020;
      dataInV[0] = 16'h2222;
      tick();
      tick();
      rst = 1'b0;
      wrV[0] = 1'b0;
      tick();
      checkOutput("abort.Stall", {15'b0, lastStall[0]}, 16'h0000);
      checkOutput("abort.DataOut", lastDout[0], 16'h0000);
      rst = 1'b1;
      idle(2);
      applyStimulus(0, 1'b1, 1'b0, 16'h0020, 16'h0000, sc, doff, dc);
      checkOutput("abort.oldValue", lastDout[0], 16'h1111);
      idle(1);

      $display("[TB] address wrap");
      applyStimulus(0, 1'b0, 1'b1, 16'h0802, 16'hA5A5, sc, doff, dc);
      applyStimulus(0, 1'b1, 1'b0, 16'h0002, 16'h0000, sc, doff, dc);
      checkOutput("wrap.DataOut", lastDout[0], 16'hA5A5);
      idle(2);

      $display("[TB] LATENCY=1 instance");
      applyStimulus(1, 1'b0, 1'b1, 16'h0040, 16'h7777, sc, doff, dc);
      checkOutput("lat1.wrStall", 16'(sc), 16'd1);
      checkOutput("lat1.wrDone", 16'(doff), 16'd1);
      applyStimulus(1, 1'b1, 1'b0, 16'h0040, 16'h0000, sc, doff, dc);
      checkOutput("lat1.rdStall", 16'(sc), 16'd1);
      checkOutput("lat1.rdDone", 16'(doff), 16'd1);
      checkOutput("lat1.DataOut", lastDout[1], 16'h7777);
      idle(3);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
